// File: rtl/arbitro_rr_4a1_pkg.sv
// Shared constants for the 4-to-1 round-robin FIFO arbiter: system mode
// encoding, FSM state encodings and a helper for sizing the burst counter.
package arbitro_rr_4a1_pkg;

  // System mode that holds the arbiter idle
  localparam logic [3:0] MODE_INIT = 4'b0001;

  // Arbiter FSM encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  // Last-served pointer after reset/INIT, so the first search starts at 0
  localparam logic [1:0] PTR_RESET = 2'd3;

  // Burst counter only has to count 0..BURST-1
  function automatic int unsigned cnt_width(input int unsigned burst);
    return (burst > 1) ? $clog2(burst) : 1;
  endfunction

endpackage

// File: rtl/arbitro_rr_4a1_prioridad_rr.sv
// Round-robin next-ready search: first ready index strictly after ptr,
// wrapping around, with ptr itself considered last.
module prioridad_rr (
  input  logic [3:0] ready,
  input  logic [1:0] ptr,
  output logic [1:0] next,
  output logic       any
);

  logic [1:0] w_idx;

  // Walk from the farthest candidate back to ptr+1 so the nearest ready one wins
  always_comb begin
    next  = ptr;
    any   = 1'b0;
    w_idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      w_idx = ptr + 2'(k);
      if (ready[w_idx]) begin
        next = w_idx;
        any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr_4a1.sv
// 4-to-1 round-robin arbiter draining four input FIFOs into one output FIFO.
// Each grant pops up to BURST words before rotating; a full output stalls
// the transfer without losing or repeating words. Output push trails the
// pop by exactly one cycle, when the popped word appears on data_in.
module arbitro_rr_4a1
  import arbitro_rr_4a1_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int BURST      = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic [3:0]            state,
  input  logic                  empty0,
  input  logic                  empty1,
  input  logic                  empty2,
  input  logic                  empty3,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic [DATA_WIDTH-1:0] data_in3,
  input  logic                  almost_full,
  output logic                  pop0,
  output logic                  pop1,
  output logic                  pop2,
  output logic                  pop3,
  output logic                  push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            grant
);

  localparam int unsigned      BW         = cnt_width(BURST);
  localparam logic [BW-1:0]    BURST_LAST = BW'(BURST - 1);

  logic [1:0]            r_fsm;
  logic [1:0]            r_grant;
  logic [1:0]            r_ptr;
  logic [BW-1:0]         r_burst;
  logic                  r_push;
  logic [1:0]            r_sel_d;

  logic [3:0]            w_ready;
  logic [3:0]            w_pop;
  logic [1:0]            w_search_ptr;
  logic [1:0]            w_next;
  logic                  w_any;
  logic                  w_init;
  logic                  w_active;
  logic                  w_grant_ready;
  logic                  w_last_pop;
  logic                  w_rotate;
  logic [DATA_WIDTH-1:0] w_din_sel;

  assign w_ready       = ~{empty3, empty2, empty1, empty0};
  assign w_init        = (state == MODE_INIT);
  // STALL behaves like SERVE as soon as the output frees up, so a stall costs
  // exactly the cycles almost_full is high
  assign w_active      = (r_fsm == ST_SERVE) || (r_fsm == ST_STALL);
  assign w_grant_ready = w_ready[r_grant];
  // From IDLE search after the last served index; when rotating, after the
  // current owner (which becomes the new last-served index)
  assign w_search_ptr  = (r_fsm == ST_IDLE) ? r_ptr : r_grant;

  prioridad_rr u_prioridad_rr (
    .ready (w_ready),
    .ptr   (w_search_ptr),
    .next  (w_next),
    .any   (w_any)
  );

  // Pop only the granted FIFO, only when it has data and the output can accept
  always_comb begin
    w_pop = 4'b0000;
    if (w_active && !w_init && !almost_full && w_grant_ready) begin
      w_pop[r_grant] = 1'b1;
    end
  end

  assign pop0 = w_pop[0];
  assign pop1 = w_pop[1];
  assign pop2 = w_pop[2];
  assign pop3 = w_pop[3];

  assign w_last_pop = (|w_pop) && (r_burst == BURST_LAST);
  assign w_rotate   = w_active && !w_init && !almost_full &&
                      (w_last_pop || !w_grant_ready);

  // Control FSM: grant ownership, burst counting, rotation and stall
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_fsm   <= ST_IDLE;
      r_grant <= 2'd0;
      r_ptr   <= PTR_RESET;
      r_burst <= '0;
    end else if (w_init) begin
      r_fsm   <= ST_IDLE;
      r_ptr   <= PTR_RESET;
      r_burst <= '0;
    end else begin
      case (r_fsm)
        ST_IDLE: begin
          if (w_any) begin
            r_fsm   <= ST_SERVE;
            r_grant <= w_next;
            r_burst <= '0;
          end
        end
        ST_SERVE, ST_STALL: begin
          if (almost_full) begin
            r_fsm <= ST_STALL;
          end else if (w_rotate) begin
            r_ptr   <= r_grant;
            r_burst <= '0;
            if (w_any) begin
              r_grant <= w_next;
              r_fsm   <= ST_SERVE;
            end else begin
              r_fsm   <= ST_IDLE;
            end
          end else begin
            r_fsm   <= ST_SERVE;
            r_burst <= r_burst + 1'b1;
          end
        end
        default: r_fsm <= ST_IDLE;
      endcase
    end
  end

  // Push trails the pop by one cycle; remember which FIFO the word came from
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_push  <= 1'b0;
      r_sel_d <= 2'd0;
    end else begin
      r_push <= |w_pop;
      if (|w_pop) begin
        r_sel_d <= r_grant;
      end
    end
  end

  // Select the word the source FIFO presents the cycle after its pop
  always_comb begin
    w_din_sel = '0;
    case (r_sel_d)
      2'd0:    w_din_sel = data_in0;
      2'd1:    w_din_sel = data_in1;
      2'd2:    w_din_sel = data_in2;
      default: w_din_sel = data_in3;
    endcase
  end

  assign push     = r_push;
  assign data_out = r_push ? w_din_sel : '0;
  assign grant    = r_grant;

endmodule

// File: tb/tb_arbitro_rr_4a1.sv
// Bench for arbitro_rr_4a1: FIFO behavioural models feed the arbiter, a
// round-robin order model predicts the pushed word sequence into a
// scoreboard, and a negedge monitor checks every push and pop.
`timescale 1ns/1ps
module tb_arbitro_rr_4a1;

  localparam int         DW    = 6;
  localparam int         BURST = 4;
  localparam logic [3:0] INIT  = 4'b0001;
  localparam logic [3:0] RUN   = 4'b0010;

  logic          clk = 1'b0;
  logic          reset_L;
  logic [3:0]    state;
  logic          almost_full;
  logic          emp [4];
  logic [DW-1:0] din [4];
  logic          pop0, pop1, pop2, pop3, push;
  logic [DW-1:0] data_out;
  logic [1:0]    grant;

  int unsigned   n_vec  = 0;
  int unsigned   n_fail = 0;
  logic [DW-1:0] fq [4][$];
  logic [DW-1:0] expq [$];
  logic [3:0]    pops_seen    = 4'b0000;
  logic          prev_pop_any = 1'b0;
  int            run_len   = 0;
  int            max_run   = 0;
  int            model_ptr = 3;

  always #5 clk = ~clk;

  arbitro_rr_4a1 #(.DATA_WIDTH(DW), .BURST(BURST)) dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .state       (state),
    .empty0      (emp[0]),
    .empty1      (emp[1]),
    .empty2      (emp[2]),
    .empty3      (emp[3]),
    .data_in0    (din[0]),
    .data_in1    (din[1]),
    .data_in2    (din[2]),
    .data_in3    (din[3]),
    .almost_full (almost_full),
    .pop0        (pop0),
    .pop1        (pop1),
    .pop2        (pop2),
    .pop3        (pop3),
    .push        (push),
    .data_out    (data_out),
    .grant       (grant)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Round-robin order model: starting after start_ptr, each nonempty FIFO in
  // turn gives min(BURST, remaining) words; the result is the push sequence.
  function automatic void rebuild(input int start_ptr);
    int cnt [4];
    int base [4];
    int p;
    int idx;
    int take;
    expq.delete();
    for (int i = 0; i < 4; i++) begin
      cnt[i]  = fq[i].size();
      base[i] = 0;
    end
    p = start_ptr;
    while (cnt[0] + cnt[1] + cnt[2] + cnt[3] > 0) begin
      idx = -1;
      for (int k = 1; k <= 4; k++) begin
        if (idx < 0 && cnt[(p + k) % 4] > 0) idx = (p + k) % 4;
      end
      take = (cnt[idx] < BURST) ? cnt[idx] : BURST;
      for (int j = 0; j < take; j++) expq.push_back(fq[idx][base[idx] + j]);
      base[idx] += take;
      cnt[idx]  -= take;
      p = idx;
    end
    model_ptr = p;
  endfunction

  function automatic void apply_pops();
    for (int i = 0; i < 4; i++) begin
      if (pops_seen[i] && fq[i].size() > 0) din[i] = fq[i].pop_front();
    end
    pops_seen = 4'b0000;
  endfunction

  function automatic void drive_empties();
    for (int i = 0; i < 4; i++) emp[i] = (fq[i].size() == 0);
  endfunction

  // One clock of stimulus: FIFO models advance, then new inputs are driven
  task automatic step(input logic af, input logic [3:0] st, input bit rb, input int rb_ptr);
    @(posedge clk);
    #1;
    apply_pops();
    almost_full = af;
    state       = st;
    if (rb) rebuild(rb_ptr);
    drive_empties();
  endtask

  // Fill all four FIFOs in the same cycle and predict the resulting order
  task automatic load(input int n0, input int n1, input int n2, input int n3);
    int n [4];
    n = '{n0, n1, n2, n3};
    @(posedge clk);
    #1;
    apply_pops();
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < n[i]; j++) fq[i].push_back(DW'($urandom));
    end
    almost_full = 1'b0;
    state       = RUN;
    rebuild(model_ptr);
    drive_empties();
  endtask

  task automatic drain(input int af_pct, input int budget);
    int c;
    c = 0;
    while ((fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size() > 0 ||
            expq.size() > 0 || prev_pop_any) && c < budget) begin
      step(($urandom_range(0, 99) < af_pct), RUN, 0, 0);
      c++;
    end
    check("drain_in_budget", 32'(c < budget), 32'd1);
    repeat (3) step(1'b0, RUN, 0, 0);
    check("scoreboard_empty", 32'(expq.size()), 32'd0);
  endtask

  // Monitor: sample away from the active edge and score every output
  always @(negedge clk) begin
    logic [3:0]    pv;
    logic [DW-1:0] e;
    pv = {pop3, pop2, pop1, pop0};
    if (!reset_L) begin
      check("rst_push", 32'(push), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_pops", 32'(pv), 32'd0);
      pops_seen    = 4'b0000;
      prev_pop_any = 1'b0;
      run_len      = 0;
    end else begin
      check("pop_onehot", 32'($countones(pv) <= 1), 32'd1);
      check("push_latency", 32'(push), 32'(prev_pop_any));
      if (push) begin
        if (expq.size() == 0) begin
          check("unexpected_push", 32'(push), 32'd0);
        end else begin
          e = expq.pop_front();
          check("data_out", 32'(data_out), 32'(e));
        end
      end
      if (almost_full || state == INIT) check("pop_blocked", 32'(pv), 32'd0);
      for (int i = 0; i < 4; i++) begin
        if (pv[i]) begin
          check("pop_matches_grant", 32'(grant), 32'(i));
          check("pop_nonempty", 32'(fq[i].size() > 0), 32'd1);
        end
      end
      pops_seen    = pv;
      prev_pop_any = |pv;
      if (|pv) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
    end
  end

  initial begin
    reset_L     = 1'b0;
    state       = RUN;
    almost_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      emp[i] = 1'b1;
      din[i] = '0;
    end

    // Reset values
    repeat (3) step(1'b0, RUN, 0, 0);
    reset_L   = 1'b1;
    model_ptr = 3;

    // Four full FIFOs: bursts of 4 then 2 in order 0,1,2,3
    max_run = 0;
    load(6, 6, 6, 6);
    drain(0, 200);
    check("burst_chain_run", 32'(max_run), 32'd18);

    // Lone requester is re-granted without a gap
    max_run = 0;
    load(0, 0, 10, 0);
    drain(0, 200);
    check("single_req_run", 32'(max_run), 32'd10);

    // almost_full for 3 cycles after the 2nd pop of FIFO0
    load(6, 3, 0, 0);
    repeat (2) step(1'b0, RUN, 0, 0);
    repeat (3) step(1'b1, RUN, 0, 0);
    drain(0, 200);

    // FIFO1 runs dry after one word mid-rotation
    load(6, 1, 5, 0);
    drain(20, 300);

    // INIT pulse while serving: restart from requester 0
    load(5, 5, 5, 5);
    repeat (6) step(1'b0, RUN, 0, 0);
    step(1'b0, INIT, 0, 0);
    step(1'b0, RUN, 1, 3);
    drain(0, 300);

    // Asynchronous reset mid-burst: pending push dropped
    load(5, 5, 5, 5);
    repeat (5) step(1'b0, RUN, 0, 0);
    step(1'b0, RUN, 0, 0);
    #2;
    reset_L = 1'b0;
    #1;
    check("async_rst_push", 32'(push), 32'd0);
    check("async_rst_data_out", 32'(data_out), 32'd0);
    check("async_rst_pops", 32'({pop3, pop2, pop1, pop0}), 32'd0);
    check("async_rst_grant", 32'(grant), 32'd0);
    step(1'b0, RUN, 0, 0);
    step(1'b0, RUN, 1, 3);
    reset_L = 1'b1;
    drain(0, 300);

    // Randomized fills with random output back-pressure
    for (int r = 0; r < 20; r++) begin
      load($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      drain(25, 400);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/arbitro_rr_4a1.md
ARBITRO_RR_4A1 -- requirements
Module: arbitro_rr_4a1

Interface
REQ-001 Parameter DATA_WIDTH, default 6, word width of every data port.
REQ-002 Parameter BURST, default 4, maximum consecutive words popped from one requester before rotation (range 1..8).
REQ-003 clk  input  1  single clock; all sequential logic on posedge clk.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 state  input  4  system mode; 4'b0001 (INIT) SHALL hold the block idle.
REQ-006 empty0..empty3  input  1 each  input FIFO i has no data.
REQ-007 data_in0..data_in3  input  DATA_WIDTH each  read data of input FIFO i, valid the cycle after its pop.
REQ-008 almost_full  input  1  shared output FIFO cannot accept more words.
REQ-009 pop0..pop3  output  1 each  read strobe to input FIFO i.
REQ-010 push  output  1  write strobe to output FIFO.
REQ-011 data_out  output  DATA_WIDTH  write data to output FIFO, valid when push=1.
REQ-012 grant  output  2  index of the requester currently owning the output.

Function
REQ-013 Requester i is "ready" when empty_i=0; at most one pop_i SHALL be 1 in any cycle.
REQ-014 FSM states: IDLE, SERVE, STALL; encoding 2 bits.
REQ-015 IDLE -> SERVE when state!=INIT and any requester ready; grant loads the first ready index searching upward (wrapping) from ptr+1, where ptr is the last served index.
REQ-016 SERVE: pop_grant = 1 combinationally while empty_grant=0 and almost_full=0; burst counter increments on each pop.
REQ-017 SERVE -> STALL when almost_full=1; pops SHALL be 0 in that same cycle (no word lost or duplicated).
REQ-018 STALL -> SERVE when almost_full=0, same grant and burst count retained.
REQ-019 Rotation: after the BURST-th pop, or when empty_grant=1 in SERVE, ptr <= grant, burst counter <= 0, grant <= next ready index by REQ-015 rule; if none ready, next state IDLE.
REQ-020 A rotating requester SHALL be granted again only after every other ready requester has been served (single-requester case: re-grant immediately).
REQ-021 push SHALL equal the OR of pop0..pop3 delayed one cycle; data_out SHALL equal data_in[sel_d], sel_d being grant registered with the pop.
REQ-022 Pop-to-push latency SHALL be exactly 1 cycle, independent of rotation or stall.
REQ-023 state=INIT in any state: next state IDLE, pops 0 immediately, burst counter 0, ptr 3; a push owed from a pop of the previous cycle SHALL still be issued.
REQ-024 Throughput: one word per cycle while granted FIFO nonempty and almost_full=0; rotation costs 0 cycles when next requester is ready.

Reset
REQ-025 reset_L=0 SHALL asynchronously force: FSM=IDLE, grant=0, ptr=3, burst counter=0, push=0, data_out=0, sel_d=0; pop0..3 SHALL be 0 during reset.
REQ-026 Reset mid-transfer SHALL drop any pending push; no push in the first cycle after reset release.

Structure
REQ-027 Shared include arbitro_defs.vh SHALL hold mode constant INIT=4'b0001 and FSM state encodings, shared with arbitro_2.
REQ-028 Next-ready search SHALL be a sub-module prioridad_rr (inputs ready[3:0], ptr[1:0]; outputs next[1:0], any); purely combinational.
REQ-029 Total RTL 120-400 lines; no latches; counters sized to BURST.

Verification
REQ-030 All four FIFOs hold 6 words, almost_full=0 -> pop order 0x4,1x4,2x4,3x4,0x2,1x2,2x2,3x2; push sequence identical, delayed 1 cycle.
REQ-031 Only FIFO2 nonempty with 10 words -> 10 consecutive pops on pop2, grant=2 throughout, then IDLE.
REQ-032 almost_full asserted for 3 cycles after 2nd pop of FIFO0 -> no pops for 3 cycles, then 2 more FIFO0 pops before rotating to 1; no word lost.
REQ-033 FIFO1 empties after 1 word mid-burst -> grant moves to 2 next cycle, ptr=1.
REQ-034 state=INIT pulsed during SERVE -> pops 0 same cycle, last popped word still pushed, restart from requester 0.
REQ-035 reset_L low mid-burst -> outputs zero asynchronously, no push after release.
